temp_stats_reader: RTL and testbench

- Read-side companion to the temperature-history writer.
- On a start pulse, scans the first N entries of the 10-entry temperature BRAM through its read port (port B, 1-cycle read latency).
- Accumulates sum, max and min, then runs a sequential divider to produce the average.
- Publishes avg/max/min with a one-cycle stats_valid pulse, for display and alarm logic downstream.

---
 rtl/temp_stats_reader.sv | 204 ++++++++++++++++++++
 tb/tb_temp_stats_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/temp_stats_reader.sv
// Scans the first N entries of the temperature BRAM, then publishes avg/max/min with a stats_valid pulse.
// Optional build macro TEMP_STATS_ROUND_EN: the average rounds half-up instead of truncating.
module temp_stats_reader #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 10,
    parameter int unsigned SUM_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   entry_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              stats_valid,
    output logic [DATA_W-1:0] avg_temp,
    output logic [DATA_W-1:0] max_temp,
    output logic [DATA_W-1:0] min_temp
);

    localparam int unsigned CNT_W = $clog2(SUM_W + 1);
    localparam logic [ADDR_W:0] N_MAX = (ADDR_W + 1)'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DIV   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state, w_state;
    logic [ADDR_W:0]   r_n, w_n;
    logic              r_rd_en, w_rd_en;
    logic [ADDR_W-1:0] r_rd_addr, w_rd_addr;
    logic              r_cap;
    logic [SUM_W-1:0]  r_sum, w_sum;
    logic [DATA_W-1:0] r_max, w_max;
    logic [DATA_W-1:0] r_min, w_min;
    logic [SUM_W-1:0]  r_quo, w_quo;
    logic [ADDR_W:0]   r_rem, w_rem;
    logic [CNT_W-1:0]  r_cnt, w_cnt;
    logic              r_busy, w_busy;
    logic              r_valid, w_valid;
    logic [DATA_W-1:0] r_avg, w_avg;
    logic [DATA_W-1:0] r_max_o, w_max_o;
    logic [DATA_W-1:0] r_min_o, w_min_o;

    logic [SUM_W-1:0]  w_fold_sum;
    logic [DATA_W-1:0] w_fold_max;
    logic [DATA_W-1:0] w_fold_min;
    logic [ADDR_W:0]   w_clamp;
    logic [ADDR_W+1:0] w_trial;
    logic [ADDR_W+1:0] w_diff;
    logic              w_sub_ok;

    // Fold of the sample returned by the BRAM this cycle
    assign w_fold_sum = r_sum + SUM_W'(rd_data);
    assign w_fold_max = (rd_data > r_max) ? rd_data : r_max;
    assign w_fold_min = (rd_data < r_min) ? rd_data : r_min;
    assign w_clamp    = (entry_count > N_MAX) ? N_MAX : entry_count;

    // Restoring divide step; remainder stays below N so it fits in ADDR_W+1 bits
    assign w_trial  = {r_rem, r_quo[SUM_W-1]};
    assign w_diff   = w_trial - {1'b0, r_n};
    assign w_sub_ok = (w_trial >= {1'b0, r_n});

    always_comb begin
        w_state   = r_state;
        w_n       = r_n;
        w_rd_en   = r_rd_en;
        w_rd_addr = r_rd_addr;
        w_sum     = r_sum;
        w_max     = r_max;
        w_min     = r_min;
        w_quo     = r_quo;
        w_rem     = r_rem;
        w_cnt     = r_cnt;
        w_valid   = 1'b0;
        w_avg     = r_avg;
        w_max_o   = r_max_o;
        w_min_o   = r_min_o;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_n = w_clamp;
                    if (w_clamp == '0) begin
                        w_quo   = '0;
                        w_max   = '0;
                        w_min   = '0;
                        w_state = S_DONE;
                    end else begin
                        w_sum     = '0;
                        w_max     = '0;
                        w_min     = '1;
                        w_rd_en   = 1'b1;
                        w_rd_addr = '0;
                        w_state   = S_READ;
                    end
                end
            end
            S_READ: begin
                if (r_cap) begin
                    w_sum = w_fold_sum;
                    w_max = w_fold_max;
                    w_min = w_fold_min;
                end
                if (r_rd_addr == ADDR_W'(r_n - (ADDR_W + 1)'(1))) begin
                    w_rd_en = 1'b0;
                    w_state = S_DRAIN;
                end else begin
                    w_rd_addr = r_rd_addr + ADDR_W'(1);
                end
            end
            S_DRAIN: begin
`ifdef TEMP_STATS_ROUND_EN
                w_sum = w_fold_sum + SUM_W'(r_n >> 1);
`else
                w_sum = w_fold_sum;
`endif
                w_max   = w_fold_max;
                w_min   = w_fold_min;
                w_cnt   = '0;
                w_state = S_DIV;
            end
            S_DIV: begin
                // First DIV cycle loads the dividend, then one quotient bit per cycle
                if (r_cnt == '0) begin
                    w_quo = r_sum;
                    w_rem = '0;
                end else begin
                    w_quo = {r_quo[SUM_W-2:0], w_sub_ok};
                    w_rem = (ADDR_W + 1)'(w_sub_ok ? w_diff : w_trial);
                end
                if (r_cnt == CNT_W'(SUM_W)) begin
                    w_state = S_DONE;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_avg   = r_quo[DATA_W-1:0];
                w_max_o = r_max;
                w_min_o = r_min;
                w_valid = 1'b1;
                w_state = S_IDLE;
            end
            default: begin
                w_rd_en = 1'b0;
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_n       <= '0;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
            r_cap     <= 1'b0;
            r_sum     <= '0;
            r_max     <= '0;
            r_min     <= '1;
            r_quo     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_avg     <= '0;
            r_max_o   <= '0;
            r_min_o   <= '1;
        end else begin
            r_state   <= w_state;
            r_n       <= w_n;
            r_rd_en   <= w_rd_en;
            r_rd_addr <= w_rd_addr;
            r_cap     <= r_rd_en;
            r_sum     <= w_sum;
            r_max     <= w_max;
            r_min     <= w_min;
            r_quo     <= w_quo;
            r_rem     <= w_rem;
            r_cnt     <= w_cnt;
            r_busy    <= w_busy;
            r_valid   <= w_valid;
            r_avg     <= w_avg;
            r_max_o   <= w_max_o;
            r_min_o   <= w_min_o;
        end
    end

    assign rd_en       = r_rd_en;
    assign rd_addr     = r_rd_addr;
    assign busy        = r_busy;
    assign stats_valid = r_valid;
    assign avg_temp    = r_avg;
    assign max_temp    = r_max_o;
    assign min_temp    = r_min_o;

endmodule

// File: tb/tb_temp_stats_reader.sv
// Scoreboard bench for temp_stats_reader: BRAM model on port B, reference stats from plain arithmetic.
module tb_temp_stats_reader;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 10;
    localparam int SUM_W  = 12;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   entry_count = '0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic              busy;
    logic              stats_valid;
    logic [DATA_W-1:0] avg_temp;
    logic [DATA_W-1:0] max_temp;
    logic [DATA_W-1:0] min_temp;

    temp_stats_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .entry_count(entry_count),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .stats_valid(stats_valid), .avg_temp(avg_temp), .max_temp(max_temp), .min_temp(min_temp)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [0:15];
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int avg;
        int mx;
        int mn;
        int n;
        int due;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int cnt, input int acc_edge);
        exp_t e;
        int n, sum;
        n = (cnt > DEPTH) ? DEPTH : cnt;
        e.n = n;
        if (n == 0) begin
            e.avg = 0; e.mx = 0; e.mn = 0;
            e.due = acc_edge + 1;
        end else begin
            sum = 0; e.mx = 0; e.mn = 255;
            for (int i = 0; i < n; i++) begin
                sum += int'(mem[i]);
                if (int'(mem[i]) > e.mx) e.mx = int'(mem[i]);
                if (int'(mem[i]) < e.mn) e.mn = int'(mem[i]);
            end
`ifdef TEMP_STATS_ROUND_EN
            e.avg = (sum + n / 2) / n;
`else
            e.avg = sum / n;
`endif
            e.due = acc_edge + n + SUM_W + 3;
        end
        return e;
    endfunction

    // Monitor: counts read traffic per transaction and pops the scoreboard on stats_valid
    int en_cnt = 0;
    int max_addr = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            en_cnt = 0;
            max_addr = 0;
        end else begin
            if (rd_en) begin
                en_cnt++;
                if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
            end
            if (stats_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_stats_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("avg", int'(avg_temp), e.avg);
                    check("max", int'(max_temp), e.mx);
                    check("min", int'(min_temp), e.mn);
                    check("latency_edge", cyc, e.due);
                    check("rd_en_cycles", en_cnt, e.n);
                    check("max_rd_addr", max_addr, (e.n == 0) ? 0 : e.n - 1);
                end
                en_cnt = 0;
                max_addr = 0;
            end
        end
    end

    // Issue one start, optionally a second start k cycles later, and wait for completion
    task automatic run(input int cnt, input int extra_at);
        bit seen = 0;
        bit busy_low = 0;
        @(negedge clk);
        start = 1'b1;
        entry_count = (ADDR_W + 1)'(cnt);
        sb.push_back(model(cnt, cyc + 1));
        for (int k = 1; k < 200; k++) begin
            @(negedge clk);
            if (k == extra_at) begin
                start = 1'b1;
                entry_count = (ADDR_W + 1)'(3);
            end else begin
                start = 1'b0;
            end
            if (stats_valid) begin
                seen = 1;
                check("busy_at_valid", int'(busy), 0);
                break;
            end
            if (!busy) busy_low = 1;
        end
        start = 1'b0;
        check("done_within_budget", int'(seen), 1);
        check("busy_held", int'(busy_low), 0);
        @(negedge clk);
        check("valid_one_cycle", int'(stats_valid), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_avg"}, int'(avg_temp), 0);
        check({tag, "_max"}, int'(max_temp), 0);
        check({tag, "_min"}, int'(min_temp), 255);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_valid"}, int'(stats_valid), 0);
        check({tag, "_rd_en"}, int'(rd_en), 0);
        check({tag, "_rd_addr"}, int'(rd_addr), 0);
    endtask

    initial begin
        bit pulse;
        for (int i = 0; i < 16; i++) mem[i] = 8'(i * 7);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 10; i++) mem[i] = 8'(20 + i);
        run(10, 0);

        mem[0] = 8'd10; mem[1] = 8'd11; mem[2] = 8'd12;
        run(3, 0);

        mem[0] = 8'd0; mem[1] = 8'd255; mem[2] = 8'd0; mem[3] = 8'd255;
        run(4, 0);

        run(0, 0);
        for (int i = 0; i < 16; i++) mem[i] = 8'(200 - i * 3);
        run(15, 0);

        for (int i = 0; i < 10; i++) mem[i] = 8'(40 + i * 5);
        run(8, 3);

        // Reset during the divide phase, then a clean rerun
        @(negedge clk);
        start = 1'b1;
        entry_count = (ADDR_W + 1)'(10);
        sb.push_back(model(10, cyc + 1));
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        @(negedge clk);
        check_reset_outputs("midrun_reset");
        rst_n = 1'b1;
        pulse = 0;
        repeat (30) begin
            @(negedge clk);
            if (stats_valid) pulse = 1;
        end
        check("no_pulse_after_reset", int'(pulse), 0);
        run(10, 0);

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 16; i++) mem[i] = 8'($urandom_range(0, 255));
            if (t % 5 == 0) for (int i = 0; i < 10; i++) mem[i] = 8'(($urandom_range(0, 1) != 0) ? 255 : 0);
            run(int'($urandom_range(0, 15)), (t % 4 == 1) ? int'($urandom_range(1, 6)) : 0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
